// File: rtl/register_file_pkg.sv
// Shared types and width helpers for the multi-port register file.
// Imported by the interface, the merge sub-module and the top level.
package register_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int calc_aw(input int regnum);
    return $clog2(regnum);
  endfunction

  function automatic int calc_bw(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Read, write and clear-control bundle between decode/writeback and the register file.
// master drives requests; slave is the register file itself.
interface register_file_mp_if
  import register_file_pkg::*;
#(
  parameter int REGNUM = 32,
  parameter int WIDTH  = 64,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  localparam int AW = calc_aw(REGNUM);
  localparam int BW = calc_bw(WIDTH);

  logic                 enable;
  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_valid;
  logic [NWR-1:0]       wr_en;
  logic [NWR*AW-1:0]    wr_addr;
  logic [NWR*BW-1:0]    wr_be;
  logic [NWR*WIDTH-1:0] wr_data;
  logic                 wr_conflict;
  logic                 clear_req;
  logic                 busy;
  logic                 clear_done;

  modport master (
    output enable, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clear_req,
    input  rd_data, rd_valid, wr_conflict, busy, clear_done
  );

  modport slave (
    input  enable, rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, clear_req,
    output rd_data, rd_valid, wr_conflict, busy, clear_done
  );

endinterface

// File: rtl/rf_write_merge.sv
// Per-byte priority merge of all write ports onto one base word at one address.
// Later (higher-index) ports overwrite earlier ones, so the highest index wins.
module rf_write_merge
  import register_file_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic [WIDTH-1:0]     base,
  input  logic [AW-1:0]        addr,
  input  logic [NWR-1:0]       wr_eff,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*WIDTH/8-1:0] wr_be,
  input  logic [NWR*WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0]     merged
);
  localparam int BW = calc_bw(WIDTH);

  always_comb begin
    merged = base;
    for (int j = 0; j < NWR; j++) begin
      if (wr_eff[j] && (wr_addr[j*AW +: AW] == addr)) begin
        for (int b = 0; b < BW; b++) begin
          if (wr_be[j*BW + b]) merged[b*8 +: 8] = wr_data[j*WIDTH + b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port byte-maskable register file with write forwarding, optional zero
// register, write-conflict flag and a sequenced background clear engine.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int REGNUM   = 32,
  parameter int WIDTH    = 64,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               reset,
  register_file_mp_if.slave bus
);
  localparam int AW = calc_aw(REGNUM);
  localparam int BW = calc_bw(WIDTH);

  logic [WIDTH-1:0]     regs_q [REGNUM];
  logic [WIDTH-1:0]     regs_d [REGNUM];
  logic [WIDTH-1:0]     merged [REGNUM];
  logic [WIDTH-1:0]     fwd    [NRD];
  logic [NWR-1:0]       wr_eff;
  logic [NRD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]       rd_valid_q, rd_valid_d;
  logic                 wr_conflict_q, wr_conflict_d;
  logic                 busy_q, busy_d;
  logic                 clear_done_q, clear_done_d;
  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;

  always_comb begin
    for (int j = 0; j < NWR; j++) begin
      wr_eff[j] = bus.enable && bus.wr_en[j] && (state_q == IDLE) &&
                  !((ZERO_REG != 0) && (bus.wr_addr[j*AW +: AW] == '0));
    end
  end

  for (genvar r = 0; r < REGNUM; r++) begin : g_reg_merge
    rf_write_merge #(.WIDTH(WIDTH), .NWR(NWR), .AW(AW)) u_merge (
      .base   (regs_q[r]),
      .addr   (AW'(r)),
      .wr_eff (wr_eff),
      .wr_addr(bus.wr_addr),
      .wr_be  (bus.wr_be),
      .wr_data(bus.wr_data),
      .merged (merged[r])
    );
  end

  // Forwarding path: each read port sees this cycle's writes to its address.
  for (genvar i = 0; i < NRD; i++) begin : g_fwd_merge
    rf_write_merge #(.WIDTH(WIDTH), .NWR(NWR), .AW(AW)) u_merge (
      .base   (regs_q[bus.rd_addr[i*AW +: AW]]),
      .addr   (bus.rd_addr[i*AW +: AW]),
      .wr_eff (wr_eff),
      .wr_addr(bus.wr_addr),
      .wr_be  (bus.wr_be),
      .wr_data(bus.wr_data),
      .merged (fwd[i])
    );
  end

  // NOTE: combinational blocks use blocking '=' with a default first so later
  // statements override earlier ones and no latch is inferred.
  always_comb begin
    for (int r = 0; r < REGNUM; r++) regs_d[r] = merged[r];
    if (state_q == CLEAR) regs_d[cnt_q] = '0;
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int i = 0; i < NRD; i++) begin
      if (bus.enable && bus.rd_en[i]) begin
        rd_valid_d[i] = 1'b1;
        if ((ZERO_REG != 0) && (bus.rd_addr[i*AW +: AW] == '0))
          rd_data_d[i*WIDTH +: WIDTH] = '0;
        else
          rd_data_d[i*WIDTH +: WIDTH] = fwd[i];
      end
    end
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      for (int k = j + 1; k < NWR; k++) begin
        if (wr_eff[j] && wr_eff[k] &&
            (bus.wr_addr[j*AW +: AW] == bus.wr_addr[k*AW +: AW]) &&
            (|(bus.wr_be[j*BW +: BW] & bus.wr_be[k*BW +: BW])))
          wr_conflict_d = 1'b1;
      end
    end
  end

  // Clear engine: one register per cycle, runs regardless of enable.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == AW'(REGNUM - 1)) begin
          state_d      = IDLE;
          busy_d       = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the array is reset along with the control flops because the block
  // guarantees all-zero contents immediately after reset; state uses '<='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REGNUM; r++) regs_q[r] <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= '0;
      wr_conflict_q <= 1'b0;
      busy_q        <= 1'b0;
      clear_done_q  <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
    end else begin
      regs_q        <= regs_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      wr_conflict_q <= wr_conflict_d;
      busy_q        <= busy_d;
      clear_done_q  <= clear_done_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.busy        = busy_q;
  assign bus.clear_done  = clear_done_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: a behavioural array model predicts every output each
// cycle; directed scenarios add hand-computed literal expectations.
module tb_register_file_mp;
  localparam int REGNUM = 32;
  localparam int WIDTH  = 64;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int AW     = 5;
  localparam int BW     = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  register_file_mp_if #(.REGNUM(REGNUM), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR)) bus ();

  register_file_mp #(
    .REGNUM(REGNUM), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] mem    [REGNUM] = '{default: '0};
  logic [WIDTH-1:0] m_next [REGNUM];
  logic [BW-1:0]    m_claim[REGNUM];
  logic [WIDTH-1:0] exp_rd [NRD] = '{default: '0};
  logic [NRD-1:0]   exp_valid = '0;
  logic             exp_conf = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic             clearing = 1'b0;
  int               clr_idx = 0;
  logic [AW-1:0]    wa, ra;
  logic [BW-1:0]    wbe;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REGNUM; r++) mem[r] = '0;
      for (int i = 0; i < NRD; i++) exp_rd[i] = '0;
      exp_valid = '0; exp_conf = 0; exp_busy = 0; exp_done = 0;
      clearing = 0; clr_idx = 0;
    end else begin
      m_next   = mem;
      m_claim  = '{default: '0};
      exp_conf = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        wa  = bus.wr_addr[j*AW +: AW];
        wbe = bus.wr_be[j*BW +: BW];
        if (bus.enable && bus.wr_en[j] && !clearing && wa != 0) begin
          if ((m_claim[wa] & wbe) != 0) exp_conf = 1'b1;
          m_claim[wa] = m_claim[wa] | wbe;
          for (int b = 0; b < BW; b++)
            if (wbe[b]) m_next[wa][8*b +: 8] = bus.wr_data[j*WIDTH + 8*b +: 8];
        end
      end
      for (int i = 0; i < NRD; i++) begin
        ra = bus.rd_addr[i*AW +: AW];
        if (bus.enable && bus.rd_en[i]) begin
          exp_rd[i]    = (ra == 0) ? '0 : m_next[ra];
          exp_valid[i] = 1'b1;
        end else begin
          exp_valid[i] = 1'b0;
        end
      end
      exp_done = 1'b0;
      if (clearing) begin
        m_next[clr_idx] = '0;
        clr_idx++;
        if (clr_idx == REGNUM) begin
          clearing = 1'b0;
          exp_done = 1'b1;
        end
      end else if (bus.clear_req) begin
        clearing = 1'b1;
        clr_idx  = 0;
      end
      exp_busy = clearing;
      mem = m_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NRD; i++)
      check($sformatf("rd_data%0d", i), bus.rd_data[i*WIDTH +: WIDTH], exp_rd[i]);
    check("rd_valid", 64'(bus.rd_valid), 64'(exp_valid));
    check("wr_conflict", 64'(bus.wr_conflict), 64'(exp_conf));
    check("busy", 64'(bus.busy), 64'(exp_busy));
    check("clear_done", 64'(bus.clear_done), 64'(exp_done));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.enable    = 1'b1;
    bus.rd_en     = '0;
    bus.rd_addr   = '0;
    bus.wr_en     = '0;
    bus.wr_addr   = '0;
    bus.wr_be     = '0;
    bus.wr_data   = '0;
    bus.clear_req = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [7:0] be, input logic [63:0] data);
    bus.wr_en[port]             = 1'b1;
    bus.wr_addr[port*AW +: AW]  = AW'(addr);
    bus.wr_be[port*BW +: BW]    = be;
    bus.wr_data[port*WIDTH +: WIDTH] = data;
  endtask

  task automatic rd(input int port, input int addr);
    bus.rd_en[port]            = 1'b1;
    bus.rd_addr[port*AW +: AW] = AW'(addr);
  endtask

  int t, busy_cnt, done_cnt;

  initial begin
    reset = 1'b1;
    drive_idle();
    repeat (2) tick();
    reset = 1'b0;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);

    // Reset then read every address on both ports.
    for (int a = 0; a < REGNUM; a += 2) begin
      drive_idle(); rd(0, a); rd(1, a + 1);
      tick();
      check("rst_read0", bus.rd_data[63:0], 64'd0);
      check("rst_read1", bus.rd_data[127:64], 64'd0);
      check("rst_valid", 64'(bus.rd_valid), 64'd3);
    end

    // Byte merge with overlapping strobes.
    drive_idle(); wr(0, 5, 8'hFF, 64'h1111_1111_1111_1111); tick();
    drive_idle();
    wr(0, 5, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
    wr(1, 5, 8'h03, 64'hBBBB_BBBB_BBBB_BBBB);
    tick();
    check("merge_conflict", 64'(bus.wr_conflict), 64'd1);
    drive_idle(); rd(0, 5); tick();
    check("merge_data", bus.rd_data[63:0], 64'h1111_1111_AAAA_BBBB);
    check("model_reg5", mem[5], 64'h1111_1111_AAAA_BBBB);
    check("merge_conflict_clr", 64'(bus.wr_conflict), 64'd0);

    // Same-cycle forwarding.
    drive_idle(); wr(0, 7, 8'hFF, 64'h0000_0000_DEAD_BEEF); rd(1, 7); tick();
    check("fwd_data", bus.rd_data[127:64], 64'h0000_0000_DEAD_BEEF);

    // Zero register ignores writes.
    drive_idle(); wr(1, 0, 8'hFF, '1); rd(0, 0); tick();
    check("zero_same", bus.rd_data[63:0], 64'd0);
    drive_idle(); rd(0, 0); tick();
    check("zero_next", bus.rd_data[63:0], 64'd0);

    // Randomized traffic, occasional clears.
    for (int n = 0; n < 600; n++) begin
      bus.enable    = ($urandom_range(0, 7) != 0);
      bus.rd_en     = NRD'($urandom);
      bus.rd_addr   = NRD*AW'($urandom);
      bus.wr_en     = NWR'($urandom);
      bus.wr_addr   = ($urandom_range(0, 1) != 0) ? NWR*AW'($urandom & 32'h0000_0063)
                                                  : NWR*AW'($urandom);
      bus.wr_be     = NWR*BW'($urandom);
      bus.wr_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.clear_req = ($urandom_range(0, 99) == 0);
      tick();
    end
    drive_idle();
    t = 0;
    while (bus.busy && t < 100) begin tick(); t++; end

    // Fill, then full clear with a dropped mid-clear write to reg3.
    for (int a = 0; a < REGNUM; a += 2) begin
      drive_idle();
      wr(0, a, 8'hFF, {$urandom, $urandom} | 64'h1);
      wr(1, a + 1, 8'hFF, {$urandom, $urandom} | 64'h1);
      tick();
    end
    drive_idle(); bus.clear_req = 1'b1; tick();
    bus.clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; t = 0;
    while (t < 100) begin
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.clear_done);
      if (bus.clear_done) break;
      if (t == 10) begin wr(0, 3, 8'hFF, 64'hFFFF_0000_FFFF_0000); bus.clear_req = 1'b1; end
      if (t == 11) drive_idle();
      tick();
      t++;
    end
    check("clear_no_timeout", 64'(t < 100), 64'd1);
    check("clear_busy_cycles", 64'(busy_cnt), 64'd32);
    drive_idle(); tick();
    check("clear_done_pulse", 64'(done_cnt), 64'd1);
    check("clear_done_low", 64'(bus.clear_done), 64'd0);
    for (int a = 0; a < REGNUM; a += 2) begin
      drive_idle(); rd(0, a); rd(1, a + 1); tick();
      check("clear_read0", bus.rd_data[63:0], 64'd0);
      check("clear_read1", bus.rd_data[127:64], 64'd0);
    end
    check("clear_reg3", mem[3], 64'd0);

    // Refill, start a clear and abort it with async reset at cnt=10.
    for (int a = 0; a < REGNUM; a += 2) begin
      drive_idle();
      wr(0, a, 8'hFF, 64'hCAFE_0000_0000_0000 | 64'(a));
      wr(1, a + 1, 8'hFF, 64'hCAFE_0000_0000_0000 | 64'(a + 1));
      tick();
    end
    drive_idle(); bus.clear_req = 1'b1; tick();
    bus.clear_req = 1'b0;
    repeat (10) tick();
    drive_idle(); rd(0, 20); rd(1, 31);
    #2;
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_rd_data", bus.rd_data[63:0] | bus.rd_data[127:64], 64'd0);
    check("abort_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("abort_done", 64'(bus.clear_done), 64'd0);
    check("abort_conflict", 64'(bus.wr_conflict), 64'd0);
    drive_idle();
    repeat (2) tick();
    reset = 1'b0;
    done_cnt = 0;
    for (int a = 0; a < REGNUM; a += 2) begin
      drive_idle(); rd(0, a); rd(1, a + 1); tick();
      done_cnt += int'(bus.clear_done);
      check("abort_read0", bus.rd_data[63:0], 64'd0);
      check("abort_read1", bus.rd_data[127:64], 64'd0);
    end
    drive_idle();
    repeat (24) begin tick(); done_cnt += int'(bus.clear_done); end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Multi-port, byte-maskable register file for the datapath. It extends the single-write, dual-read file with parametrised read and write port counts and per-byte write strobes. It also adds deterministic write-port priority, full write-to-read forwarding, an optional hardwired zero register, and a sequenced background clear engine. It sits between instruction decode (reads) and writeback (writes) in multi-issue configurations.

## Interface
Parameters:
- REGNUM, 32, number of registers (≥2, power of two).
- WIDTH, 64, register width in bits (multiple of 8).
- NRD, 2, number of read ports (≥1).
- NWR, 2, number of write ports (≥1).
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes.
- Derived: AW = $clog2(REGNUM), BW = WIDTH/8.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  global port enable for reads and writes.
- rd_en  in  NRD  per-port read request.
- rd_addr  in  NRD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NRD*WIDTH  registered read data.
- rd_valid  out  NRD  high for one cycle with each new rd_data.
- wr_en  in  NWR  per-port write request.
- wr_addr  in  NWR*AW  write addresses.
- wr_be  in  NWR*BW  byte strobes; bit b covers bits [8b +: 8].
- wr_data  in  NWR*WIDTH  write data.
- wr_conflict  out  1  registered pulse: two or more active writes hit the same address and byte in the previous cycle.
- clear_req  in  1  start background clear (sampled in IDLE only).
- busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when clear completes.

## Operation
- **Effective write.** Port j is effective when enable & wr_en[j] & state==IDLE & !(ZERO_REG & wr_addr[j]==0).
- **Write merge.** For each address and byte, the highest-index effective port with its strobe set wins. Bytes with no strobe keep their old value.
- **Read.** When enable & rd_en[i], rd_data[i] gets the register value with the same cycle's merged effective writes overlaid per byte (forwarding). If ZERO_REG is set and the address is 0, the result is 0. rd_valid[i] is set to 1.
- **Read not requested.** When rd_en[i]=0 or enable=0, rd_data[i] holds its previous value and rd_valid[i]=0. The output never goes to 'z.
- **wr_conflict.** Set if any two effective ports share an address and have at least one common strobe bit. Otherwise 0.
- **Clear FSM** (states IDLE, CLEAR):
  - IDLE → CLEAR on clear_req; the counter loads 0.
  - In CLEAR, register[cnt] ← 0 each cycle and cnt increments. This proceeds regardless of enable.
  - When cnt == REGNUM-1 is cleared: CLEAR → IDLE and clear_done pulses.
  - clear_req in CLEAR is ignored.
  - External writes in CLEAR are dropped. Reads proceed and return the current array contents, so registers not yet cleared return their old values.
- **Reset.** Asynchronously sets every register to 0, rd_data to 0, rd_valid to 0, wr_conflict to 0, busy to 0, clear_done to 0, state to IDLE, and cnt to 0.

## Timing
- Read latency is 1 cycle: address sampled at edge N, data and rd_valid visible after edge N.
- A write sampled at edge N is visible to a non-forwarded read sampled at edge N+1. The same-edge case is covered by forwarding.
- busy is 1 from the edge after clear_req is accepted through the edge that clears register REGNUM-1.
- The full clear takes REGNUM cycles.
- clear_done is registered and is high for the single cycle after the last clear write.
- A clear_req coinciding with writes in IDLE is accepted. Those writes still commit at that edge, and the clear then overwrites them.
- Reset asserted during CLEAR aborts immediately. The array is zeroed asynchronously and no clear_done is generated.
- wr_conflict has 1-cycle latency relative to the offending writes.

## Structure
- Package register_file_pkg contains:
  - the state typedef (IDLE, CLEAR);
  - the helper functions for BW/AW derivation.
- Sub-module rf_write_merge: combinational per-byte priority merge of NWR ports onto one base word for one address.
  - Instantiated once per register for the array update.
  - Instantiated once per read port for forwarding.
- The top level holds the array, read registers, conflict detection, and the clear FSM and counter.

## Test plan
- Reset then read: read all addresses on both ports → rd_data=0, rd_valid=1 one cycle after each request.
- Byte merge: reg5=0x1111_1111_1111_1111. Port0 writes reg5 be=0x0F data=0xAA…AA and port1 writes reg5 be=0x03 data=0xBB…BB in the same cycle → reg5=0x1111_1111_AAAA_BBBB, wr_conflict=1 next cycle.
- Forwarding: write reg7=0xDEAD_BEEF be=0xFF while reading reg7 in the same cycle → rd_data=0x0000_0000_DEAD_BEEF one cycle later.
- Zero register (ZERO_REG=1): write reg0=0xFFFF… then read reg0 on the same and the next cycle → both reads return 0.
- Clear: fill all registers, pulse clear_req, attempt a write to reg3 mid-clear → busy for 32 cycles, clear_done one pulse, every register reads 0, reg3 write dropped.
- Async reset mid-clear: assert reset between edges at cnt=10 → busy=0 and all outputs 0 immediately; after release, all reads return 0 and there is no clear_done.
